// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read RAM between the fetch port and the load/store port.
// Data wins arbitration unless fetch has already lost MAX_WAIT times in a row.
module mem_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  contention_cnt
);
  localparam int WAIT_W = 4;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

  state_t            state_p0, state_nxt;
  logic [WAIT_W-1:0] wait_cnt_p0, wait_cnt_nxt;
  logic              d_wr_p0, d_wr_nxt;
  logic [CNT_W-1:0]  cont_p0;
  logic              if_win, both_req;

  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c, if_rdata_c, d_rdata_c;
  logic              mem_we_c, mem_re_c, if_ready_c, d_ready_c;

  function automatic logic [WAIT_W-1:0] sat_wait(input logic [WAIT_W-1:0] v);
    return (v >= WAIT_MAX) ? WAIT_MAX : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign both_req = if_req & d_req;
  assign if_win   = if_req & (~d_req | (wait_cnt_p0 >= WAIT_MAX));

  // State register and counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_p0    <= IDLE;
      wait_cnt_p0 <= '0;
      d_wr_p0     <= 1'b0;
      cont_p0     <= '0;
    end else begin
      state_p0    <= state_nxt;
      wait_cnt_p0 <= wait_cnt_nxt;
      d_wr_p0     <= d_wr_nxt;
      if (state_p0 == IDLE && both_req)
        cont_p0 <= sat_cnt(cont_p0);
    end
  end

  always_comb begin
    state_nxt    = state_p0;
    wait_cnt_nxt = wait_cnt_p0;
    d_wr_nxt     = d_wr_p0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;
    mem_we_c     = 1'b0;
    mem_re_c     = 1'b0;
    if_ready_c   = 1'b0;
    if_rdata_c   = '0;
    d_ready_c    = 1'b0;
    d_rdata_c    = '0;
    case (state_p0)
      IDLE: begin
        if (if_win) begin
          mem_addr_c = if_addr;
          mem_re_c   = 1'b1;
          state_nxt  = IF_BUSY;
        end else if (d_req) begin
          mem_addr_c  = d_addr;
          mem_wdata_c = d_wdata;
          mem_we_c    = d_we;
          mem_re_c    = ~d_we;
          d_wr_nxt    = d_we;
          state_nxt   = D_BUSY;
        end
        // Fetch that is requesting but not granted has just lost to data
        if (if_win || !if_req) wait_cnt_nxt = '0;
        else                   wait_cnt_nxt = sat_wait(wait_cnt_p0);
      end
      IF_BUSY: begin
        if_ready_c = 1'b1;
        if_rdata_c = mem_rdata;
        state_nxt  = IDLE;
      end
      D_BUSY: begin
        d_ready_c = 1'b1;
        d_rdata_c = d_wr_p0 ? '0 : mem_rdata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Everything is forced quiet while reset is held, even with requests pending
  assign mem_addr       = RST ? '0 : mem_addr_c;
  assign mem_wdata      = RST ? '0 : mem_wdata_c;
  assign mem_we         = mem_we_c & ~RST;
  assign mem_re         = mem_re_c & ~RST;
  assign if_ready       = if_ready_c & ~RST;
  assign if_rdata       = RST ? '0 : if_rdata_c;
  assign d_ready        = d_ready_c & ~RST;
  assign d_rdata        = RST ? '0 : d_rdata_c;
  assign contention_cnt = cont_p0;

endmodule
